// File: rtl/lsu_mem_if.sv
// Load/store unit: one data-memory transaction per request over a valid/ready bus,
// with lane steering, load extension and bus timeout. Optional macro: LSU_MISALIGN_TRAP_EN.
module lsu_mem_if #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic             we_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic              mem_valid_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_wstrb_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic        req_legal;
    logic        req_misal;
    logic        req_ok;
    logic [1:0]  off_d;
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;
    logic [31:0] rdata_d;
    logic [31:0] shifted;
    logic        timeout_hit;

    // Request decode: legality, effective lane offset and store lane steering
    always_comb begin
        if (req_we)
            req_legal = funct3 inside {3'b000, 3'b001, 3'b010};
        else
            req_legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

`ifdef LSU_MISALIGN_TRAP_EN
        req_misal = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
        req_misal = 1'b0;
`endif
        req_ok = req_legal && !req_misal;

        // Without the trap, low bits below the access size are simply ignored
        case (funct3[1:0])
            2'b00:   off_d = addr[1:0];
            2'b01:   off_d = {addr[1], 1'b0};
            default: off_d = 2'b00;
        endcase

        case (funct3[1:0])
            2'b00: begin
                wstrb_d = 4'b0001 << off_d;
                wdata_d = {4{wdata[7:0]}};
            end
            2'b01: begin
                wstrb_d = 4'b0011 << off_d;
                wdata_d = {2{wdata[15:0]}};
            end
            default: begin
                wstrb_d = 4'b1111;
                wdata_d = wdata;
            end
        endcase
        if (!req_we)
            wstrb_d = '0;
    end

    // Load extraction from the returned word
    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  rdata_d = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  rdata_d = {24'h0, shifted[7:0]};
            3'b001:  rdata_d = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  rdata_d = {16'h0, shifted[15:0]};
            default: rdata_d = mem_rdata;
        endcase
        if (we_q)
            rdata_d = '0;
    end

    // Saturating wait counter; ready in the final cycle still completes normally
    always_comb begin
        if (cnt_q == CNT_W'(TIMEOUT_CYCLES))
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + CNT_W'(1);
        timeout_hit = (TIMEOUT_CYCLES != 0) && !mem_ready &&
                      (cnt_d == CNT_W'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid)
                    state_d = req_ok ? S_REQ : S_DONE;
            end
            S_REQ: begin
                if (mem_ready || timeout_hit)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stall = ((state_q == S_IDLE) && req_valid) || (state_q == S_REQ);
        done  = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            we_q        <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
            cnt_q       <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (req_valid) begin
                        if (req_ok) begin
                            we_q        <= req_we;
                            f3_q        <= funct3;
                            off_q       <= off_d;
                            mem_valid_q <= 1'b1;
                            mem_we_q    <= req_we;
                            mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                            mem_wstrb_q <= wstrb_d;
                            mem_wdata_q <= wdata_d;
                        end else begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        mem_valid_q <= 1'b0;
                        rdata_q     <= rdata_d;
                        err_q       <= 1'b0;
                    end else if (timeout_hit) begin
                        mem_valid_q <= 1'b0;
                        rdata_q     <= '0;
                        err_q       <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: a transaction-level model sets per-cycle
// expectations, a negedge checker compares every cycle.
module tb_lsu_mem_if;

    localparam int unsigned TMO = 16;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    lsu_mem_if #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Per-cycle expectations
    bit          chk_on = 0;
    bit          exp_rst = 0;
    bit          exp_stall, exp_done, exp_mv, exp_err;
    logic        exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_res, exp_rdata;
    logic [3:0]  exp_wstrb;
    bit          exp_bad;
    // Hand-computed literals for the current vector
    bit          lit_on = 0;
    logic [31:0] lit_addr, lit_wdata, lit_rdata;
    logic [3:0]  lit_wstrb;
    bit          lit_err;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] ex);
        total++;
        if (act !== ex) begin
            bad++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, ex);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("stall", 32'(stall), 32'(exp_stall));
            cmp("done", 32'(done), 32'(exp_done));
            cmp("mem_valid", 32'(mem_valid), 32'(exp_mv));
            if (exp_rst) begin
                cmp("rst_mem_we", 32'(mem_we), 32'd0);
                cmp("rst_mem_addr", mem_addr, 32'd0);
                cmp("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
                cmp("rst_mem_wdata", mem_wdata, 32'd0);
                cmp("rst_rdata", rdata, 32'd0);
                cmp("rst_err", 32'(err), 32'd0);
            end
            if (exp_mv) begin
                cmp("mem_addr", mem_addr, exp_addr);
                cmp("mem_we", 32'(mem_we), 32'(exp_we));
                cmp("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
                if (exp_we) cmp("mem_wdata", mem_wdata, exp_wdata);
                if (lit_on) begin
                    cmp("lit_mem_addr", mem_addr, lit_addr);
                    cmp("lit_mem_wstrb", 32'(mem_wstrb), 32'(lit_wstrb));
                    if (exp_we) cmp("lit_mem_wdata", mem_wdata, lit_wdata);
                end
            end
            if (exp_done) begin
                cmp("rdata", rdata, exp_rdata);
                cmp("err", 32'(err), 32'(exp_err));
                if (lit_on) begin
                    cmp("lit_rdata", rdata, lit_rdata);
                    cmp("lit_err", 32'(err), 32'(lit_err));
                end
            end
        end
    end

    // Transaction-level model, plain arithmetic on the access rules
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rw);
        int unsigned sz;
        int unsigned off;
        bit legal;
        bit mis;
        logic [31:0] sh;
        logic [31:0] v;
        sz    = int'(f3[1:0]);
        legal = we ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        mis   = 0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
`endif
        off = (sz == 0) ? (a % 4) : (sz == 1) ? ((a % 4) / 2) * 2 : 0;
        exp_bad  = !legal || mis;
        exp_addr = (a / 4) * 4;
        exp_we   = we;
        if (!we)          exp_wstrb = 4'd0;
        else if (sz == 0) exp_wstrb = 4'(1 << off);
        else if (sz == 1) exp_wstrb = 4'(3 << off);
        else              exp_wstrb = 4'd15;
        if (sz == 0)      exp_wdata = (wd % 256) * 32'h0101_0101;
        else if (sz == 1) exp_wdata = (wd % 65536) * 32'h0001_0001;
        else              exp_wdata = wd;
        sh = rw >> (8 * off);
        v  = rw;
        case (f3)
            3'd0: begin v = sh % 256;   if (v >= 128)   v = v - 256;   end
            3'd4: v = sh % 256;
            3'd1: begin v = sh % 65536; if (v >= 32768) v = v - 65536; end
            3'd5: v = sh % 65536;
            default: v = rw;
        endcase
        exp_res = we ? 32'd0 : v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle();
        exp_rst = 0; exp_stall = 0; exp_done = 0; exp_mv = 0;
    endtask

    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rw,
                           input int dly, input bit never);
        int nreq;
        model(we, f3, a, wd, rw);
        step();
        req_valid = 1; req_we = we; funct3 = f3; addr = a; wdata = wd;
        mem_rdata = rw; mem_ready = (dly == 0);
        exp_rst = 0; exp_stall = 1; exp_done = 0; exp_mv = 0;
        if (!exp_bad) begin
            nreq = never ? TMO : dly + 1;
            for (int k = 1; k <= nreq; k++) begin
                step();
                mem_ready = (!never && k == dly + 1);
                exp_stall = 1; exp_done = 0; exp_mv = 1;
            end
        end
        step();
        mem_ready = 0;
        exp_stall = 0; exp_done = 1; exp_mv = 0;
        exp_err   = exp_bad || never;
        exp_rdata = (exp_bad || never) ? 32'd0 : exp_res;
        // req_valid stays high through DONE: must not re-issue
        step();
        req_valid = 0;
        expect_idle();
        lit_on = 0;
    endtask

    task automatic set_lit(input logic [31:0] la, input logic [3:0] ls, input logic [31:0] lw,
                           input logic [31:0] lr, input bit le);
        lit_on = 1; lit_addr = la; lit_wstrb = ls; lit_wdata = lw; lit_rdata = lr; lit_err = le;
    endtask

    initial begin
        reset = 0; req_valid = 1; req_we = 0; funct3 = 3'd2; addr = 32'h40;
        wdata = 0; mem_ready = 0; mem_rdata = 0;
        exp_we = 0; exp_addr = 0; exp_wdata = 0; exp_res = 0; exp_rdata = 0;
        exp_wstrb = 0; exp_bad = 0; exp_err = 0;
        lit_addr = 0; lit_wdata = 0; lit_rdata = 0; lit_wstrb = 0; lit_err = 0;

        // Reset held two cycles with a pending request
        step();
        chk_on = 1; exp_rst = 1; exp_stall = 1; exp_done = 0; exp_mv = 0;
        step();
        step();
        reset = 1; req_valid = 0; exp_stall = 0;
        step();
        expect_idle(); mem_ready = 1;
        step();
        mem_ready = 0;

        set_lit(32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 32'h0, 0);
        run_txn(1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0);
        set_lit(32'h0000_2000, 4'b0000, 32'h0, 32'hFFFF_FF80, 0);
        run_txn(0, 3'b000, 32'h0000_2001, 32'h0, 32'h1234_80FF, 0, 0);
        set_lit(32'h0000_2000, 4'b0000, 32'h0, 32'h0000_0080, 0);
        run_txn(0, 3'b100, 32'h0000_2001, 32'h0, 32'h1234_80FF, 1, 0);
        set_lit(32'h0000_2000, 4'b0000, 32'h0, 32'h0000_1234, 0);
        run_txn(0, 3'b101, 32'h0000_2002, 32'h0, 32'h1234_80FF, 0, 0);
        set_lit(32'h0000_2000, 4'b0000, 32'h0, 32'hFFFF_8001, 0);
        run_txn(0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_0000, 2, 0);
        set_lit(32'h0000_2000, 4'b0000, 32'h0, 32'h0000_00AB, 0);
        run_txn(0, 3'b100, 32'h0000_2003, 32'h0, 32'hAB00_0000, 0, 0);
        set_lit(32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0, 0);
        run_txn(1, 3'b001, 32'h0000_2002, 32'h1234_BEEF, 32'h0, 0, 0);
        set_lit(32'h0000_1000, 4'b0001, 32'h7878_7878, 32'h0, 0);
        run_txn(1, 3'b000, 32'h0000_1000, 32'h1234_5678, 32'h0, 1, 0);
        set_lit(32'h0000_2004, 4'b1111, 32'hDEAD_BEEF, 32'h0, 0);
        run_txn(1, 3'b010, 32'h0000_2004, 32'hDEAD_BEEF, 32'h0, 2, 0);

        // Wait states, then timeout and ready on the last permitted cycle
        set_lit(32'h0000_4000, 4'b0000, 32'h0, 32'hCAFE_F00D, 0);
        run_txn(0, 3'b010, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 5, 0);
        set_lit(32'h0000_5000, 4'b0000, 32'h0, 32'h0, 1);
        run_txn(0, 3'b010, 32'h0000_5000, 32'h0, 32'h1111_2222, 0, 1);
        set_lit(32'h0000_5000, 4'b0000, 32'h0, 32'h1111_2222, 0);
        run_txn(0, 3'b010, 32'h0000_5000, 32'h0, 32'h1111_2222, TMO - 1, 0);

        // Misaligned and illegal requests
`ifdef LSU_MISALIGN_TRAP_EN
        set_lit(32'h0, 4'b0000, 32'h0, 32'h0, 1);
        run_txn(0, 3'b001, 32'h0000_3001, 32'h0, 32'h1122_3344, 0, 0);
        set_lit(32'h0, 4'b0000, 32'h0, 32'h0, 1);
        run_txn(1, 3'b010, 32'h0000_3003, 32'h5555_6666, 32'h0, 0, 0);
`else
        set_lit(32'h0000_3000, 4'b0000, 32'h0, 32'h0000_3344, 0);
        run_txn(0, 3'b001, 32'h0000_3001, 32'h0, 32'h1122_3344, 0, 0);
        set_lit(32'h0000_3000, 4'b1111, 32'h5555_6666, 32'h0, 0);
        run_txn(1, 3'b010, 32'h0000_3003, 32'h5555_6666, 32'h0, 0, 0);
`endif
        set_lit(32'h0, 4'b0000, 32'h0, 32'h0, 1);
        run_txn(0, 3'b011, 32'h0000_2000, 32'h0, 32'h9999_9999, 0, 0);
        set_lit(32'h0, 4'b0000, 32'h0, 32'h0, 1);
        run_txn(1, 3'b100, 32'h0000_2000, 32'h7777_7777, 32'h0, 0, 0);

        // Reset in the middle of a transaction: abandoned, no done
        model(0, 3'b010, 32'h0000_6000, 32'h0, 32'h0);
        step();
        req_valid = 1; req_we = 0; funct3 = 3'b010; addr = 32'h0000_6000; mem_ready = 0;
        exp_stall = 1; exp_done = 0; exp_mv = 0;
        step();
        exp_mv = 1;
        step();
        reset = 0;
        step();
        reset = 1; req_valid = 0;
        exp_rst = 1; exp_stall = 0; exp_done = 0; exp_mv = 0;
        step();
        expect_idle();
        step();
        step();

        chk_on = 0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
